viterbi_traceback: RTL and testbench

Traceback stage of the K=3, rate-1/2, 4-state Viterbi decoder; sits directly downstream of the ACS array and the minimum-state selector. Each trellis step it stores the 4 ACS survivor decision bits. When a block of DEPTH steps has been stored, it traces back from the best end state and emits the DEPTH decoded bits in forward (time) order over a valid/ready stream.

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/tb_decision_ram.sv | 26 ++
 rtl/viterbi_traceback.sv | 134 +++++++++++++
 tb/tb_viterbi_traceback.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3, 4-state Viterbi traceback.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int STATE_W    = 2;

    // Trellis state {u[t], u[t-1]}, newest bit in the MSB
    typedef enum logic [STATE_W-1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        EMIT  = 2'd2
    } tb_fsm_t;

endpackage

// File: rtl/tb_decision_ram.sv
// Survivor decision store: DEPTH words of NUM_STATES bits.
// One synchronous write port and one combinational read port. Contents are not reset.
module tb_decision_ram
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [NUM_STATES-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [NUM_STATES-1:0] rdata
);

    logic [NUM_STATES-1:0] mem [DEPTH];

    // Write one decision vector per accepted trellis step
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: store DEPTH decision vectors, trace back from the best
// end state, then stream the decoded bits out in time order.
// Optional macro VITERBI_TB_ZERO_START_EN: trace back from state 00 and
// ignore min_state (zero-tailed frames).
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STATES-1:0] dec,
    input  logic [STATE_W-1:0]    min_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last,
    output logic                  busy
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    tb_fsm_t               state_q, state_d;
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]      emit_cnt_q, emit_cnt_d;
    state_t                tb_state_q, tb_state_d;
    logic [DEPTH-1:0]      bits_q, bits_d;
    logic                  ram_we;
    logic [NUM_STATES-1:0] rd_data;
    state_t                start_state;

`ifdef VITERBI_TB_ZERO_START_EN
    logic unused_min_state;
    assign unused_min_state = ^min_state;
    assign start_state      = S00;
`else
    assign start_state      = state_t'(min_state);
`endif

    tb_decision_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (dec),
        .raddr (rd_idx_q),
        .rdata (rd_data)
    );

    // Next-state logic: fill, trace back one step per cycle, then emit
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        emit_cnt_d = emit_cnt_q;
        tb_state_d = tb_state_q;
        bits_d     = bits_q;
        ram_we     = 1'b0;
        case (state_q)
            FILL: begin
                // in_ready is high throughout FILL, so in_valid alone is a handshake
                if (in_valid) begin
                    ram_we = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        wr_ptr_d   = '0;
                        tb_state_d = start_state;
                        rd_idx_d   = LAST;
                        state_d    = TRACE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            TRACE: begin
                // Decoded bit is the state's MSB; predecessor is {s[0], dec[s]}
                bits_d[rd_idx_q] = tb_state_q[1];
                tb_state_d       = state_t'({tb_state_q[0], rd_data[tb_state_q]});
                if (rd_idx_q == '0) begin
                    emit_cnt_d = '0;
                    state_d    = EMIT;
                end else begin
                    rd_idx_d = rd_idx_q - 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (emit_cnt_q == LAST) begin
                        emit_cnt_d = '0;
                        state_d    = FILL;
                    end else begin
                        emit_cnt_d = emit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control state register; a reset discards any partial block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            emit_cnt_q <= '0;
            tb_state_q <= S00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_idx_q   <= rd_idx_d;
            emit_cnt_q <= emit_cnt_d;
            tb_state_q <= tb_state_d;
        end
    end

    // Decoded bit buffer; only meaningful once TRACE has rewritten it
    always_ff @(posedge clk) begin
        bits_q <= bits_d;
    end

    // Outputs come from registers and FSM state only
    assign in_ready  = (state_q == FILL);
    assign busy      = (state_q == TRACE) || (state_q == EMIT);
    assign out_valid = (state_q == EMIT);
    assign out_bit   = (state_q == EMIT) ? bits_q[emit_cnt_q] : 1'b0;
    assign out_last  = (state_q == EMIT) && (emit_cnt_q == LAST);

endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomized bench for viterbi_traceback against a behavioural traceback model.
module tb_viterbi_traceback;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dec = '0;
    logic [1:0] min_state = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    viterbi_traceback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec       (dec),
        .min_state (min_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: walk the survivor path backwards from the start state.
    // Bit at step t is the current state's MSB; previous state is {s[0], dec[t][s]}.
    function automatic logic [DEPTH-1:0] model(input logic [3:0] d [DEPTH], input int start);
        logic [DEPTH-1:0] b;
        int s;
`ifdef VITERBI_TB_ZERO_START_EN
        s = 0;
`else
        s = start;
`endif
        b = '0;
        for (int t = DEPTH - 1; t >= 0; t--) begin
            b[t] = s[1];
            s = ((s & 1) << 1) | int'(d[t][s]);
        end
        return b;
    endfunction

    // Feed DEPTH decision vectors; gap_pct = chance of an idle cycle before each write.
    // Non-final writes carry a random min_state that must not influence the result.
    task automatic fill_block(input logic [3:0] d [DEPTH], input logic [1:0] ms, input int gap_pct);
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(negedge clk);
                in_valid  = 1'b0;
                dec       = 4'($urandom);
                min_state = 2'($urandom);
                @(posedge clk);
            end
            @(negedge clk);
            chk("in_ready_fill", 32'(in_ready), 32'd1);
            in_valid  = 1'b1;
            dec       = d[i];
            min_state = (i == DEPTH - 1) ? ms : 2'($urandom);
            @(posedge clk);
        end
    endtask

    // After the last write: check TRACE length, in_ready low, then drain the bits.
    task automatic drain_block(input logic [DEPTH-1:0] exp, input int stall_at,
                               input int stall_len, input int bp_pct);
        int waited;
        waited = 0;
        // Junk input during TRACE/EMIT must be ignored
        do begin
            @(negedge clk);
            waited++;
            in_valid  = 1'b1;
            dec       = 4'($urandom);
            min_state = 2'($urandom);
            out_ready = 1'b0;
            if (!out_valid) begin
                chk("in_ready_trace", 32'(in_ready), 32'd0);
                chk("busy_trace", 32'(busy), 32'd1);
            end
        end while (!out_valid && waited < 4 * DEPTH);
        chk("first_valid_latency", 32'(waited), 32'(DEPTH + 1));
        if (!out_valid) return;
        for (int j = 0; j < DEPTH; j++) begin
            if (j == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    out_ready = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_bit", 32'(out_bit), 32'(exp[j]));
                    chk("stall_last", 32'(out_last), 32'(j == DEPTH - 1));
                end
            end
            while ($urandom_range(99) < bp_pct) begin
                out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("in_ready_emit", 32'(in_ready), 32'd0);
            chk("out_bit", 32'(out_bit), 32'(exp[j]));
            chk("out_last", 32'(out_last), 32'(j == DEPTH - 1));
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after_last", 32'(in_ready), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
        chk("out_valid_after_last", 32'(out_valid), 32'd0);
    endtask

    task automatic run_block(input logic [3:0] d [DEPTH], input logic [1:0] ms, input int gap_pct,
                             input int stall_at, input int stall_len, input int bp_pct);
        fill_block(d, ms, gap_pct);
        drain_block(model(d, int'(ms)), stall_at, stall_len, bp_pct);
    endtask

    initial begin
        logic [3:0] d [DEPTH];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // All-ones decisions from state 11
        foreach (d[i]) d[i] = 4'b1111;
        run_block(d, 2'b11, 0, -1, 0, 0);

        // All-zero decisions from state 11
        foreach (d[i]) d[i] = 4'b0000;
        run_block(d, 2'b11, 0, -1, 0, 0);

        // All-zero decisions from state 10, input valid every other cycle
        run_block(d, 2'b10, 50, -1, 0, 0);

        // Random decisions, 5-cycle stall on the 3rd bit
        foreach (d[i]) d[i] = 4'($urandom);
        run_block(d, 2'($urandom), 0, 2, 5, 0);

        // Stall on the final bit
        foreach (d[i]) d[i] = 4'($urandom);
        run_block(d, 2'($urandom), 0, DEPTH - 1, 3, 0);

        // Reset mid-TRACE discards the block
        foreach (d[i]) d[i] = 4'($urandom);
        fill_block(d, 2'b01, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy_pre_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (d[i]) d[i] = 4'($urandom);
        run_block(d, 2'b10, 0, -1, 0, 0);

        // Back-to-back blocks with different start states
        foreach (d[i]) d[i] = 4'($urandom);
        run_block(d, 2'b01, 0, -1, 0, 0);
        foreach (d[i]) d[i] = 4'($urandom);
        run_block(d, 2'b10, 0, -1, 0, 0);

        // Randomized gaps and backpressure
        for (int n = 0; n < 24; n++) begin
            foreach (d[i]) d[i] = 4'($urandom);
            run_block(d, 2'($urandom), 30, -1, 0, 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
